// File: rtl/kbitset_pkg.sv
// Shared types and helpers for the K-bits-set sequence generator.
// first_comb/last_comb return 32-bit words; callers truncate to their width.
package kbitset_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned k_width(input int unsigned bw);
        return $clog2(bw + 1);
    endfunction

    // Lowest word with k bits set: k ones packed at bit 0.
    function automatic logic [31:0] first_comb(input int unsigned k);
        return (k >= 32) ? '1 : ((32'd1 << k) - 32'd1);
    endfunction

    // Highest word with k bits set in a bw-bit field: ones packed at the top.
    function automatic logic [31:0] last_comb(input int unsigned k, input int unsigned bw);
        return first_comb(k) << (bw - k);
    endfunction

endpackage

// File: rtl/kbitset_seq_gen_if.sv
// Output stream of the K-bits-set generator: valid/ready with last and index sideband.
interface kbitset_seq_gen_if #(
    parameter int BW_NUM = 8,
    parameter int IDX_W  = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [BW_NUM-1:0] outnum;
    logic              out_last;
    logic [IDX_W-1:0]  out_idx;

    modport master (
        output out_valid, outnum, out_last, out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid, outnum, out_last, out_idx,
        output out_ready
    );
endinterface

// File: rtl/kbitset_next.sv
// Combinational successor: next larger word with the same number of set bits.
// The input must not already be the highest combination; that case returns cur.
module kbitset_next #(
    parameter int BW_NUM = 8
) (
    input  logic [BW_NUM-1:0] cur,
    output logic [BW_NUM-1:0] nxt
);

    always_comb begin
        logic        found;
        int unsigned pos;
        int unsigned ones;
        found = 1'b0;
        pos   = 0;
        ones  = 0;
        nxt   = cur;
        // Locate the lowest "10" pair (bit j set, bit j+1 clear), counting ones beneath it.
        for (int unsigned j = 0; j < BW_NUM - 1; j++) begin
            if (!found) begin
                if (cur[j] && !cur[j+1]) begin
                    found = 1'b1;
                    pos   = j;
                end else if (cur[j]) begin
                    ones = ones + 1;
                end
            end
        end
        for (int unsigned j = 0; j < BW_NUM; j++) begin
            if (!found)              nxt[j] = cur[j];
            else if (j < ones)       nxt[j] = 1'b1;
            else if (j <= pos)       nxt[j] = 1'b0;
            else if (j == pos + 1)   nxt[j] = 1'b1;
            else                     nxt[j] = cur[j];
        end
    end

endmodule

// File: rtl/kbitset_seq_gen.sv
// Walks every BW_NUM-bit word with exactly K bits set, in increasing order,
// over a valid/ready stream; one-shot or wrapping, restartable at any time.
module kbitset_seq_gen
    import kbitset_pkg::*;
#(
    parameter  int BW_NUM = 8,
    parameter  int IDX_W  = 16,
    localparam int K_W    = k_width(BW_NUM)
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      start,
    input  logic [K_W-1:0]            k_cfg,
    input  logic                      mode_wrap,
    kbitset_seq_gen_if.master         stream,
    output logic                      busy,
    output logic                      cfg_err
);

    state_t            state;
    logic [K_W-1:0]    k_lat;
    logic              wrap_lat;
    logic [BW_NUM-1:0] nxt;
    logic [BW_NUM-1:0] first_new;
    logic [BW_NUM-1:0] first_cur;
    logic [BW_NUM-1:0] last_cur;
    logic              k_legal;

    kbitset_next #(.BW_NUM(BW_NUM)) u_next (
        .cur (stream.outnum),
        .nxt (nxt)
    );

    always_comb begin
        k_legal   = (k_cfg != '0) && (k_cfg <= K_W'(BW_NUM));
        first_new = BW_NUM'(first_comb(32'(k_cfg)));
        first_cur = BW_NUM'(first_comb(32'(k_lat)));
        last_cur  = BW_NUM'(last_comb(32'(k_lat), BW_NUM));
    end

    assign busy = (state == RUN);

    // start outranks a simultaneous transfer, so it is tested first.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state            <= IDLE;
            k_lat            <= '0;
            wrap_lat         <= 1'b0;
            cfg_err          <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.outnum    <= '0;
            stream.out_last  <= 1'b0;
            stream.out_idx   <= '0;
        end else begin
            cfg_err <= 1'b0;
            if (start) begin
                if (k_legal) begin
                    state            <= RUN;
                    k_lat            <= k_cfg;
                    wrap_lat         <= mode_wrap;
                    stream.out_valid <= 1'b1;
                    stream.outnum    <= first_new;
                    stream.out_last  <= (k_cfg == K_W'(BW_NUM));
                    stream.out_idx   <= '0;
                end else begin
                    state            <= IDLE;
                    cfg_err          <= 1'b1;
                    stream.out_valid <= 1'b0;
                    stream.out_last  <= 1'b0;
                end
            end else if (state == RUN && stream.out_ready) begin
                if (!stream.out_last) begin
                    stream.outnum   <= nxt;
                    stream.out_idx  <= stream.out_idx + 1'b1;
                    stream.out_last <= (nxt == last_cur);
                end else if (wrap_lat) begin
                    stream.outnum   <= first_cur;
                    stream.out_idx  <= '0;
                    stream.out_last <= (k_lat == K_W'(BW_NUM));
                end else begin
                    state            <= IDLE;
                    stream.out_valid <= 1'b0;
                    stream.out_last  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_kbitset_seq_gen.sv
// Scoreboard bench for kbitset_seq_gen at BW_NUM=4 and BW_NUM=8; expected
// words come from a Gosper's-hack model pushed to a queue as stimulus is issued.
module tb_kbitset_seq_gen;

    typedef struct {
        int unsigned num;
        int unsigned idx;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    logic       start4, wrap4, busy4, err4;
    logic [2:0] k4;
    logic       start8, wrap8, busy8, err8;
    logic [3:0] k8;

    kbitset_seq_gen_if #(.BW_NUM(4), .IDX_W(16)) if4 ();
    kbitset_seq_gen_if #(.BW_NUM(8), .IDX_W(16)) if8 ();

    kbitset_seq_gen #(.BW_NUM(4), .IDX_W(16)) dut4 (
        .clk(clk), .rst_b(rst_b), .start(start4), .k_cfg(k4), .mode_wrap(wrap4),
        .stream(if4), .busy(busy4), .cfg_err(err4)
    );

    kbitset_seq_gen #(.BW_NUM(8), .IDX_W(16)) dut8 (
        .clk(clk), .rst_b(rst_b), .start(start8), .k_cfg(k8), .mode_wrap(wrap8),
        .stream(if8), .busy(busy8), .cfg_err(err8)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t e;

    function automatic int unsigned gosper(input int unsigned x);
        int unsigned c, r;
        c = x & (~x + 1);
        r = x + c;
        return (((r ^ x) >> 2) / c) | r;
    endfunction

    task automatic push_seq(input int unsigned bw, input int unsigned k, input int unsigned count);
        int unsigned f, l, x, idx;
        f   = (1 << k) - 1;
        l   = f << (bw - k);
        x   = f;
        idx = 0;
        repeat (count) begin
            q.push_back('{num: x, idx: idx, last: (x == l)});
            if (x == l) begin
                x   = f;
                idx = 0;
            end else begin
                x   = gosper(x);
                idx = idx + 1;
            end
        end
    endtask

    task automatic test_reset;
        rst_b = 1'b0;
        start4 = 1'b0; k4 = '0; wrap4 = 1'b0; if4.out_ready = 1'b0;
        start8 = 1'b0; k8 = '0; wrap8 = 1'b0; if8.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid8: got %b want 0", if8.out_valid); end
        checks++; if (if8.outnum !== 8'h00) begin errors++; $display("FAIL reset_num8: got %h want 00", if8.outnum); end
        checks++; if (if8.out_idx !== 16'h0) begin errors++; $display("FAIL reset_idx8: got %h want 0", if8.out_idx); end
        checks++; if (if8.out_last !== 1'b0) begin errors++; $display("FAIL reset_last8: got %b want 0", if8.out_last); end
        checks++; if (busy8 !== 1'b0 || err8 !== 1'b0) begin errors++; $display("FAIL reset_busy_err8: got %b%b want 00", busy8, err8); end
        checks++; if (if4.out_valid !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL reset_dut4: got %b%b want 00", if4.out_valid, busy4); end
        rst_b = 1'b1;
        @(negedge clk);
        checks++; if (if8.out_valid !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("FAIL reset_release: got %b%b want 00", if8.out_valid, busy8); end
    endtask

    task automatic test_oneshot4;
        @(negedge clk);
        start4 = 1'b1; k4 = 3'd2; wrap4 = 1'b0; if4.out_ready = 1'b1;
        push_seq(4, 2, 6);
        for (int c = 0; c < 12 && q.size() > 0; c++) begin
            @(negedge clk);
            start4 = 1'b0;
            e = q[0];
            checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL os4_valid: got %b want 1 at idx %0d", if4.out_valid, e.idx); end
            checks++; if (32'(if4.outnum) !== e.num) begin errors++; $display("FAIL os4_num: got %h want %h", if4.outnum, e.num); end
            checks++; if (32'(if4.out_idx) !== e.idx) begin errors++; $display("FAIL os4_idx: got %0d want %0d", if4.out_idx, e.idx); end
            checks++; if (if4.out_last !== e.last) begin errors++; $display("FAIL os4_last: got %b want %b", if4.out_last, e.last); end
            void'(q.pop_front());
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL os4_timeout: got %0d left want 0", q.size()); q.delete(); end
        @(negedge clk);
        checks++; if (if4.out_valid !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL os4_end: got valid %b busy %b want 0 0", if4.out_valid, busy4); end
        if4.out_ready = 1'b0;
    endtask

    task automatic test_wrap8;
        int unsigned prev;
        prev = 0;
        @(negedge clk);
        start8 = 1'b1; k8 = 4'd3; wrap8 = 1'b1; if8.out_ready = 1'b1;
        push_seq(8, 3, 57);
        for (int c = 0; c < 60 && q.size() > 0; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            e = q[0];
            checks++; if (if8.out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1 at step %0d", if8.out_valid, c); end
            checks++; if (32'(if8.outnum) !== e.num) begin errors++; $display("FAIL wrap_num: got %h want %h", if8.outnum, e.num); end
            checks++; if (32'(if8.out_idx) !== e.idx) begin errors++; $display("FAIL wrap_idx: got %0d want %0d", if8.out_idx, e.idx); end
            checks++; if (if8.out_last !== e.last) begin errors++; $display("FAIL wrap_last: got %b want %b", if8.out_last, e.last); end
            if (e.idx != 0) begin
                checks++; if (32'(if8.outnum) <= prev) begin errors++; $display("FAIL wrap_order: got %h want above %h", if8.outnum, prev); end
            end
            prev = 32'(if8.outnum);
            void'(q.pop_front());
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL wrap_timeout: got %0d left want 0", q.size()); q.delete(); end
    endtask

    task automatic test_cfg_err;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            start8 = 1'b1; k8 = (t == 0) ? 4'd0 : 4'd9; wrap8 = 1'b0;
            @(negedge clk);
            start8 = 1'b0;
            checks++; if (err8 !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse: got %b want 1 for k %0d", err8, k8); end
            checks++; if (if8.out_valid !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("FAIL cfg_err_idle: got %b%b want 00", if8.out_valid, busy8); end
            @(negedge clk);
            checks++; if (err8 !== 1'b0 || if8.out_valid !== 1'b0) begin errors++; $display("FAIL cfg_err_width: got err %b valid %b want 0 0", err8, if8.out_valid); end
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        start8 = 1'b1; k8 = 4'd3; wrap8 = 1'b0; if8.out_ready = 1'b1;
        push_seq(8, 3, 3);
        for (int c = 0; c < 8 && q.size() > 0; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            e = q[0];
            checks++; if (if8.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1 at step %0d", if8.out_valid, c); end
            checks++; if (32'(if8.outnum) !== e.num) begin errors++; $display("FAIL bp_num: got %h want %h at step %0d", if8.outnum, e.num, c); end
            checks++; if (32'(if8.out_idx) !== e.idx) begin errors++; $display("FAIL bp_idx: got %0d want %0d", if8.out_idx, e.idx); end
            checks++; if (if8.out_last !== e.last) begin errors++; $display("FAIL bp_last: got %b want %b", if8.out_last, e.last); end
            if8.out_ready = (c == 0 || c >= 6);
            if (if8.out_ready) void'(q.pop_front());
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL bp_timeout: got %0d left want 0", q.size()); q.delete(); end
    endtask

    task automatic test_restart;
        @(negedge clk);
        start8 = 1'b1; k8 = 4'd2; wrap8 = 1'b0; if8.out_ready = 1'b1;
        push_seq(8, 2, 6);
        for (int c = 0; c < 8 && q.size() > 0; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            e = q[0];
            checks++; if (32'(if8.outnum) !== e.num || if8.out_valid !== 1'b1) begin errors++; $display("FAIL rs_num: got %h valid %b want %h valid 1", if8.outnum, if8.out_valid, e.num); end
            void'(q.pop_front());
            if (q.size() == 0) begin
                start8 = 1'b1; k8 = 4'd2;
            end
        end
        @(negedge clk);
        start8 = 1'b0;
        checks++; if (if8.outnum !== 8'h03) begin errors++; $display("FAIL rs_first: got %h want 03", if8.outnum); end
        checks++; if (if8.out_idx !== 16'd0) begin errors++; $display("FAIL rs_idx: got %0d want 0", if8.out_idx); end
        checks++; if (if8.out_valid !== 1'b1 || if8.out_last !== 1'b0) begin errors++; $display("FAIL rs_flags: got valid %b last %b want 1 0", if8.out_valid, if8.out_last); end
    endtask

    task automatic test_k_bounds;
        @(negedge clk);
        start8 = 1'b1; k8 = 4'd8; wrap8 = 1'b0; if8.out_ready = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        checks++; if (if8.outnum !== 8'hFF || if8.out_last !== 1'b1 || if8.out_valid !== 1'b1) begin errors++; $display("FAIL k8_word: got %h last %b valid %b want ff 1 1", if8.outnum, if8.out_last, if8.out_valid); end
        @(negedge clk);
        checks++; if (if8.out_valid !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("FAIL k8_end: got %b%b want 00", if8.out_valid, busy8); end
        start8 = 1'b1; wrap8 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            checks++; if (if8.outnum !== 8'hFF || if8.out_idx !== 16'd0 || if8.out_last !== 1'b1 || if8.out_valid !== 1'b1) begin
                errors++; $display("FAIL k8_wrap: got %h idx %0d last %b valid %b want ff 0 1 1", if8.outnum, if8.out_idx, if8.out_last, if8.out_valid);
            end
        end
        start8 = 1'b1; k8 = 4'd1; wrap8 = 1'b0;
        push_seq(8, 1, 8);
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            e = q[0];
            checks++; if (32'(if8.outnum) !== e.num || if8.out_valid !== 1'b1) begin errors++; $display("FAIL k1_num: got %h want %h", if8.outnum, e.num); end
            checks++; if (if8.out_last !== e.last || 32'(if8.out_idx) !== e.idx) begin errors++; $display("FAIL k1_side: got last %b idx %0d want %b %0d", if8.out_last, if8.out_idx, e.last, e.idx); end
            void'(q.pop_front());
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL k1_timeout: got %0d left want 0", q.size()); q.delete(); end
        @(negedge clk);
        checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL k1_end: got %b want 0", if8.out_valid); end
    endtask

    task automatic test_midreset;
        @(negedge clk);
        start8 = 1'b1; k8 = 4'd2; wrap8 = 1'b0; if8.out_ready = 1'b1;
        push_seq(8, 2, 5);
        for (int c = 0; c < 8 && q.size() > 0; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            e = q[0];
            checks++; if (32'(if8.outnum) !== e.num || 32'(if8.out_idx) !== e.idx) begin errors++; $display("FAIL mr_pre: got %h idx %0d want %h %0d", if8.outnum, if8.out_idx, e.num, e.idx); end
            void'(q.pop_front());
        end
        #2 rst_b = 1'b0;
        #1;
        checks++; if (if8.out_valid !== 1'b0 || if8.out_last !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("FAIL mr_async_flags: got valid %b last %b busy %b want 0 0 0", if8.out_valid, if8.out_last, busy8); end
        checks++; if (if8.outnum !== 8'h00 || if8.out_idx !== 16'd0) begin errors++; $display("FAIL mr_async_data: got %h idx %0d want 00 0", if8.outnum, if8.out_idx); end
        @(negedge clk);
        rst_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (if8.out_valid !== 1'b0 || busy8 !== 1'b0 || if8.outnum !== 8'h00 || err8 !== 1'b0) begin
                errors++; $display("FAIL mr_quiet: got valid %b busy %b num %h err %b want 0 0 00 0", if8.out_valid, busy8, if8.outnum, err8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot4();
        test_wrap8();
        test_cfg_err();
        test_backpressure();
        test_restart();
        test_k_bounds();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
